// File: rtl/ssaes_pkg.sv
// Shared SSAES444 definitions: FSM states, GF(2^4) field constants and the
// nibble multiplier used by the column mixers.
package ssaes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] GF_POLY_LOW = 4'h3;

    localparam logic [3:0] INV_COEF_E = 4'hE;
    localparam logic [3:0] INV_COEF_B = 4'hB;
    localparam logic [3:0] INV_COEF_D = 4'hD;
    localparam logic [3:0] INV_COEF_9 = 4'h9;

    // First row of the inverse circulant; element 0 is the leftmost nibble.
    localparam logic [0:3][3:0] INV_ROW = {INV_COEF_E, INV_COEF_B, INV_COEF_D, INV_COEF_9};

    // Carry-less multiply into 7 bits, then fold bits 6..4 back using x^4 = poly.
    function automatic logic [3:0] gf16_mul(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] poly);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ 7'({3'b000, a} << i);
        end
        for (int i = 6; i >= 4; i--) begin
            if (p[i]) p = p ^ 7'({2'b00, 1'b1, poly} << (i - 4));
        end
        return p[3:0];
    endfunction

endpackage

// File: rtl/inv_mix_column_col.sv
// Combinational InvMixColumns of a single 4-nibble column (row 0 is the
// most-significant nibble).
module inv_mix_column_col
    import ssaes_pkg::*;
#(
    parameter logic [3:0] POLY_LOW = ssaes_pkg::GF_POLY_LOW
) (
    input  logic [0:3][3:0] col_in,
    output logic [0:3][3:0] col_out
);

    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                col_out[r] = col_out[r] ^ gf16_mul(INV_ROW[2'(k - r)], col_in[k], POLY_LOW);
            end
        end
    end

endmodule

// File: rtl/inv_mix_column_seq.sv
// Sequential InvMixColumns for a 64-bit SSAES444 state: one column per cycle
// through a single shared column mixer, valid/ready on both sides.
module inv_mix_column_seq
    import ssaes_pkg::*;
#(
    parameter logic [3:0] GF_POLY_LOW = ssaes_pkg::GF_POLY_LOW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_state,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_state
);

    state_t          state_q, state_d;
    logic [1:0]      col_q, col_d;
    logic [63:0]     work_q, work_d;
    logic [0:3][3:0] col_sel;
    logic [0:3][3:0] col_mix;

    always_comb begin
        col_sel = work_q[63:48];
        case (col_q)
            2'd0: col_sel = work_q[63:48];
            2'd1: col_sel = work_q[47:32];
            2'd2: col_sel = work_q[31:16];
            2'd3: col_sel = work_q[15:0];
            default: col_sel = work_q[63:48];
        endcase
    end

    inv_mix_column_col #(
        .POLY_LOW(GF_POLY_LOW)
    ) u_col (
        .col_in (col_sel),
        .col_out(col_mix)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    col_d   = 2'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                case (col_q)
                    2'd0: work_d[63:48] = col_mix;
                    2'd1: work_d[47:32] = col_mix;
                    2'd2: work_d[31:16] = col_mix;
                    2'd3: work_d[15:0]  = col_mix;
                    default: work_d = work_q;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= 2'd0;
            work_q  <= 64'h0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_state = work_q;

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// Scoreboarded bench for inv_mix_column_seq: directed vectors, stall and reset
// scenarios, and a forward/inverse round trip on random states.
module tb_inv_mix_column_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_state;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_state;

    always #5 clk = ~clk;

    inv_mix_column_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_state (in_state),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_state(out_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit hold_low = 1'b0;
    bit rnd_ready = 1'b0;
    bit prev_valid = 1'b0;
    logic [63:0] exp_q[$];
    int exp_tab[15];
    int log_tab[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // GF(16) via exp/log tables generated by x, which is primitive for x^4+x+1.
    function automatic void build_tables();
        int v = 1;
        for (int i = 0; i < 15; i++) begin
            exp_tab[i] = v;
            log_tab[v] = i;
            v = v << 1;
            if (v >= 16) v = v ^ 'h13;
        end
        log_tab[0] = 0;
    endfunction

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_tab[(log_tab[a] + log_tab[b]) % 15];
    endfunction

    function automatic int nib(input logic [63:0] s, input int c, input int r);
        return int'((s >> (60 - 16 * c - 4 * r)) & 64'hF);
    endfunction

    function automatic logic [63:0] fwd_mix(input logic [63:0] s);
        int coef[4] = '{2, 3, 1, 1};
        logic [63:0] o = 64'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                int acc = 0;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], nib(s, c, k));
                o = o | (64'(acc) << (60 - 16 * c - 4 * r));
            end
        end
        return o;
    endfunction

    // Monitor: drives out_ready and checks every handshaken output.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_low)       out_ready = 1'b0;
            else if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            else                out_ready = 1'b1;
            if (out_valid === 1'b1 && !prev_valid) chk("latency", 64'(cyc - acc_cyc), 64'd4);
            prev_valid = (out_valid === 1'b1);
            if (out_valid === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=no_output", out_state);
                end else begin
                    chk("out_state", out_state, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [63:0] s, input logic [63:0] e, input bit push);
        int n = 0;
        if (push) exp_q.push_back(e);
        in_valid = 1'b1;
        in_state = s;
        while (in_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
            in_valid = 1'b0;
            return;
        end
        acc_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
    endtask

    initial begin
        logic [63:0] held;
        int n;
        build_tables();
        rst = 1'b1;
        in_valid = 1'b0;
        in_state = 64'h0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_work", out_state, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        send(64'h1000_1000_1000_1000, 64'hE9DB_E9DB_E9DB_E9DB, 1'b1);
        send(64'h2113_2113_2113_2113, 64'h1000_1000_1000_1000, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        send(64'h0, 64'h0, 1'b1);
        drain();

        // Consumer stall in DONE: output frozen and new inputs refused.
        hold_low = 1'b1;
        send(64'h2113_0000_1000_FFFF, 64'h1000_0000_E9DB_FFFF, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_done", 64'(out_valid), 64'd1);
        held = out_state;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_state = {$urandom, $urandom};
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_out_state", out_state, held);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        hold_low = 1'b0;
        drain();

        // Reset mid-computation at column 2: block dropped, nothing emitted.
        send({$urandom, $urandom}, 64'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_work", out_state, 64'h0);
        repeat (10) @(negedge clk);

        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] s;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            s = {$urandom, $urandom};
            send(fwd_mix(s), s, 1'b1);
        end
        drain();
        repeat (10) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
